code_run_logger: RTL

CODE_RUN_LOGGER -- requirements
Module: code_run_logger

---
 rtl/code_run_logger.sv | 137 +++++++++++++
 1 files changed

// File: rtl/code_run_logger.sv
`default_nettype none
// ============================================================================
// Module   : code_run_logger
// Purpose  : Run-length logger for an 8-bit state code. Each completed run is
//            queued as a {code, dwell} record in a show-ahead FIFO.
// Option   : CODE_RUN_LOGGER_DROP_CNT_EN adds a saturating DROP_CNT output.
// Revision : 1.0 - initial release
// ============================================================================
module code_run_logger #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [7:0]                 CODE,
  input  logic                       EN,
  output logic                       EV_VALID,
  input  logic                       EV_READY,
  output logic [7:0]                 EV_CODE,
  output logic [CNT_W-1:0]           EV_DWELL,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       DROP,
  output logic                       OVF
`ifdef CODE_RUN_LOGGER_DROP_CNT_EN
  ,
  output logic [7:0]                 DROP_CNT
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_RW = 8 + CNT_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state, w_state_nx;
  logic [7:0]        r_last_code, w_last_nx;
  logic [CNT_W-1:0]  r_dwell, w_dwell_nx;
  logic              w_push;

  logic [c_RW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_LW-1:0]   r_level;
  logic              r_drop, r_ovf;
  logic              w_full, w_pop, w_wr_en, w_drop;
  logic [c_RW-1:0]   w_head;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_last_code <= 8'h00;
      r_dwell     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_last_code <= w_last_nx;
      r_dwell     <= w_dwell_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_last_nx  = r_last_code;
    w_dwell_nx = r_dwell;
    w_push     = 1'b0;
    if (EN) begin
      if (r_state == S_IDLE) begin
        w_state_nx = S_RUN;
        w_last_nx  = CODE;
        w_dwell_nx = CNT_W'(1);
      end else if (CODE == r_last_code) begin
        if (r_dwell != {CNT_W{1'b1}}) w_dwell_nx = r_dwell + CNT_W'(1);
      end else begin
        w_push     = 1'b1;
        w_last_nx  = CODE;
        w_dwell_nx = CNT_W'(1);
      end
    end
  end

  // A pop frees the slot the same-cycle push lands in, so full+pop never drops.
  assign w_full  = (r_level == c_LW'(DEPTH));
  assign w_pop   = EV_VALID && EV_READY;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {r_last_code, r_dwell};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase
      r_drop <= w_drop;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef CODE_RUN_LOGGER_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_drop_cnt <= 8'h00;
    end else if (w_drop && (r_drop_cnt != 8'hff)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end

  assign DROP_CNT = r_drop_cnt;
`endif

  // Head fields are masked so an empty FIFO presents zeros.
  assign w_head   = EV_VALID ? r_mem[r_rd_ptr] : '0;
  assign EV_VALID = (r_level != '0);
  assign EV_CODE  = w_head[c_RW-1:CNT_W];
  assign EV_DWELL = w_head[CNT_W-1:0];
  assign LEVEL    = r_level;
  assign DROP     = r_drop;
  assign OVF      = r_ovf;

endmodule
`default_nettype wire
